// File: rtl/datapath_mc_pkg.sv
// Shared definitions for the datapath_mc multicycle datapath: FSM state
// encoding, RV32I opcode/funct3 values, next-PC and write-back select codes,
// ALU operation codes and the reset value of the instruction register.
package datapath_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct3 values that change immediate decoding (shift-immediates)
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  // Next-PC select
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  // Write-back select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0,x0,0

endpackage

// File: rtl/datapath_mc_imm_gen.sv
// imm_gen: purely combinational immediate decoder.
// Ports:
//   i_ir  [31:0]     instruction word
//   o_imm [XLEN-1:0] immediate, sign-extended to XLEN. B- and J-type return
//                    the offset without its always-zero bit 0 (imm[12:1],
//                    imm[20:1]); the PC adder shifts it back.
module imm_gen
  import datapath_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_ir,
  output logic [XLEN-1:0] o_imm
);

  logic signed [11:0] w_imm_i;
  logic signed [11:0] w_imm_s;
  logic signed [11:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [19:0] w_imm_j;

  assign w_imm_i = i_ir[31:20];
  assign w_imm_s = {i_ir[31:25], i_ir[11:7]};
  assign w_imm_b = {i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8]};
  assign w_imm_u = {i_ir[31:12], 12'h000};
  assign w_imm_j = {i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21]};

  // Size casts of signed operands sign-extend to XLEN.
  always_comb begin
    o_imm = '0;
    case (i_ir[6:0])
      OPC_OP_IMM: begin
        if (i_ir[14:12] == F3_SLL || i_ir[14:12] == F3_SR)
          o_imm = XLEN'(i_ir[24:20]);
        else
          o_imm = XLEN'(w_imm_i);
      end
      OPC_LOAD, OPC_JALR: o_imm = XLEN'(w_imm_i);
      OPC_STORE:          o_imm = XLEN'(w_imm_s);
      OPC_BRANCH:         o_imm = XLEN'(w_imm_b);
      OPC_LUI, OPC_AUIPC: o_imm = XLEN'(w_imm_u);
      OPC_JAL:            o_imm = XLEN'(w_imm_j);
      default:            o_imm = '0;
    endcase
  end

endmodule

// File: rtl/datapath_mc.sv
// datapath_mc: multicycle RV32I-style datapath driven by an external control
// unit. FETCH -> DECODE -> EXEC -> [MEM] -> WB, with a sticky FAULT state
// entered when a data access is not acknowledged within MEM_TIMEOUT cycles.
// Ports:
//   clk, rst (async, active low)
//   instr/iValid/iReq        instruction fetch handshake; IR to control unit
//   ALUSrc, ALUCtrl, MemRead, MemWrite, RegWrite, WBSel, PCSel  control in
//   PC, Zero                 program counter, latched ALU zero flag
//   dReq/dWe/dAddress/dWriteData/dReadData/dAck  data memory port
//   WriteBackData            value written to rd
//   fault, busy              sticky timeout flag, not-in-FETCH indicator
module datapath_mc
  import datapath_mc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] INITIAL_PC  = XLEN'(32'h00400000),
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            iValid,
  output logic            iReq,
  output logic [31:0]     IR,
  input  logic            ALUSrc,
  input  logic [3:0]      ALUCtrl,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic [1:0]      WBSel,
  input  logic [1:0]      PCSel,
  output logic [XLEN-1:0] PC,
  output logic            Zero,
  output logic            dReq,
  output logic            dWe,
  output logic [XLEN-1:0] dAddress,
  output logic [XLEN-1:0] dWriteData,
  input  logic [XLEN-1:0] dReadData,
  input  logic            dAck,
  output logic [XLEN-1:0] WriteBackData,
  output logic            fault,
  output logic            busy
);

  localparam int TW  = $clog2(MEM_TIMEOUT + 1);
  localparam int SHW = $clog2(XLEN);

  state_e          r_state, w_state_next;
  logic            r_run;  // first clock after reset release seen
  logic [XLEN-1:0] r_pc, r_a, r_b, r_imm, r_alu_out, r_mdr;
  logic [31:0]     r_ir;
  logic            r_zero, r_fault;
  logic [TW-1:0]   r_tmo;
  logic [XLEN-1:0] r_rf [32];  // not reset

  logic [XLEN-1:0] w_imm, w_op2, w_alu_res, w_pc_plus4, w_pc_target, w_pc_next;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  logic [SHW-1:0]  w_shamt;
  logic            w_rf_we;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_ir  (r_ir),
    .o_imm (w_imm)
  );

  // Register file: x0 is never written and always reads as zero.
  assign w_rs1_val = (r_ir[19:15] == 5'd0) ? '0 : r_rf[r_ir[19:15]];
  assign w_rs2_val = (r_ir[24:20] == 5'd0) ? '0 : r_rf[r_ir[24:20]];
  assign w_rf_we   = (r_state == S_WB) && RegWrite && (r_ir[11:7] != 5'd0);

  always_ff @(posedge clk) begin
    if (w_rf_we) r_rf[r_ir[11:7]] <= WriteBackData;
  end

  // ALU
  assign w_op2   = ALUSrc ? r_imm : r_b;
  assign w_shamt = w_op2[SHW-1:0];

  always_comb begin
    w_alu_res = '0;
    case (ALUCtrl)
      ALU_ADD:  w_alu_res = r_a + w_op2;
      ALU_SUB:  w_alu_res = r_a - w_op2;
      ALU_AND:  w_alu_res = r_a & w_op2;
      ALU_OR:   w_alu_res = r_a | w_op2;
      ALU_XOR:  w_alu_res = r_a ^ w_op2;
      ALU_SLL:  w_alu_res = r_a << w_shamt;
      ALU_SRL:  w_alu_res = r_a >> w_shamt;
      ALU_SRA:  w_alu_res = $signed(r_a) >>> w_shamt;
      ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_op2))};
      ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (r_a < w_op2)};
      ALU_PASS: w_alu_res = w_op2;
      default:  w_alu_res = '0;
    endcase
  end

  // Next PC and write-back value, both from the pre-update PC.
  assign w_pc_plus4  = r_pc + XLEN'(4);
  assign w_pc_target = r_pc + (r_imm << 1);

  always_comb begin
    w_pc_next = w_pc_plus4;
    case (PCSel)
      PC_PLUS4:  w_pc_next = w_pc_plus4;
      PC_BRANCH: w_pc_next = r_zero ? w_pc_target : w_pc_plus4;
      PC_JAL:    w_pc_next = w_pc_target;
      PC_JALR:   w_pc_next = r_alu_out & ~XLEN'(1);
      default:   w_pc_next = w_pc_plus4;
    endcase
  end

  always_comb begin
    WriteBackData = r_alu_out;
    case (WBSel)
      WB_ALU:  WriteBackData = r_alu_out;
      WB_MEM:  WriteBackData = r_mdr;
      WB_PC4:  WriteBackData = w_pc_plus4;
      WB_IMM:  WriteBackData = r_imm;
      default: WriteBackData = r_alu_out;
    endcase
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  if (r_run && iValid) w_state_next = S_DECODE;
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC:   w_state_next = (MemRead || MemWrite) ? S_MEM : S_WB;
      S_MEM: begin
        if (dAck)                              w_state_next = S_WB;
        else if (r_tmo == TW'(MEM_TIMEOUT - 1)) w_state_next = S_FAULT;
      end
      S_WB:     w_state_next = S_FETCH;
      S_FAULT:  w_state_next = S_FAULT;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Strobes decode registered state only, so they cannot glitch. iReq is also
  // held off until the first clock after reset release.
  assign iReq       = r_run && (r_state == S_FETCH);
  assign dReq       = (r_state == S_MEM);
  assign dWe        = (r_state == S_MEM) && MemWrite;  // read+write acts as store
  assign dAddress   = r_alu_out;
  assign dWriteData = r_b;
  assign busy       = (r_state != S_FETCH);
  assign IR         = r_ir;
  assign PC         = r_pc;
  assign Zero       = r_zero;
  assign fault      = r_fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_run     <= 1'b0;
      r_pc      <= INITIAL_PC;
      r_ir      <= NOP_INSTR;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      r_zero    <= 1'b0;
      r_fault   <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= 1'b1;
      r_tmo   <= '0;
      case (r_state)
        S_FETCH:  if (r_run && iValid) r_ir <= instr;
        S_DECODE: begin
          r_a   <= w_rs1_val;
          r_b   <= w_rs2_val;
          r_imm <= w_imm;
        end
        S_EXEC: begin
          r_alu_out <= w_alu_res;
          r_zero    <= (w_alu_res == '0);
        end
        S_MEM: begin
          if (dAck) r_mdr <= dReadData;
          else      r_tmo <= r_tmo + TW'(1);
          if (w_state_next == S_FAULT) r_fault <= 1'b1;
        end
        S_WB:     r_pc <= w_pc_next;
        default: ;
      endcase
    end
  end

endmodule
